// File: rtl/pooling_pkg.sv
// Shared geometry of the drawing-area frame buffer and pooled image,
// plus the state encoding of the pooling engine.
package pooling_pkg;

    localparam int IN_DIM     = 224;
    localparam int POOL       = 8;
    localparam int OUT_DIM    = IN_DIM / POOL;
    localparam int OUT_BITS   = 8;
    localparam int FB_ADDR_W  = 16;
    localparam int OUT_ADDR_W = 10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/pool_addr_gen.sv
// Nested window (kx, ky) and cell (bx, by) counters producing the frame-buffer
// read address and the pooled-image cell index.
module pool_addr_gen #(
    parameter int IN_DIM     = pooling_pkg::IN_DIM,
    parameter int POOL       = pooling_pkg::POOL,
    parameter int FB_ADDR_W  = pooling_pkg::FB_ADDR_W,
    parameter int OUT_ADDR_W = pooling_pkg::OUT_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  step_k,
    input  logic                  step_cell,
    output logic [FB_ADDR_W-1:0]  fb_addr,
    output logic [OUT_ADDR_W-1:0] cell_idx,
    output logic                  last_in_window,
    output logic                  last_cell
);

    localparam int OUT_DIM = IN_DIM / POOL;
    localparam int K_W     = $clog2(POOL);
    localparam int C_W     = $clog2(OUT_DIM);

    logic [K_W-1:0] kx_q, kx_d, ky_q, ky_d;
    logic [C_W-1:0] bx_q, bx_d, by_q, by_d;
    logic [FB_ADDR_W-1:0] row, col;

    // A window step wraps kx into ky; the ky wrap is natural because POOL is a power of two.
    always_comb begin
        kx_d = kx_q;
        ky_d = ky_q;
        bx_d = bx_q;
        by_d = by_q;
        if (clear) begin
            kx_d = '0;
            ky_d = '0;
            bx_d = '0;
            by_d = '0;
        end else if (step_cell) begin
            kx_d = '0;
            ky_d = '0;
            if (bx_q == C_W'(OUT_DIM - 1)) begin
                bx_d = '0;
                by_d = by_q + 1'b1;
            end else begin
                bx_d = bx_q + 1'b1;
            end
        end else if (step_k) begin
            if (kx_q == K_W'(POOL - 1)) begin
                kx_d = '0;
                ky_d = ky_q + 1'b1;
            end else begin
                kx_d = kx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kx_q <= '0;
            ky_q <= '0;
            bx_q <= '0;
            by_q <= '0;
        end else begin
            kx_q <= kx_d;
            ky_q <= ky_d;
            bx_q <= bx_d;
            by_q <= by_d;
        end
    end

    assign row      = FB_ADDR_W'(by_q) * FB_ADDR_W'(POOL) + FB_ADDR_W'(ky_q);
    assign col      = FB_ADDR_W'(bx_q) * FB_ADDR_W'(POOL) + FB_ADDR_W'(kx_q);
    assign fb_addr  = row * FB_ADDR_W'(IN_DIM) + col;
    assign cell_idx = OUT_ADDR_W'(by_q) * OUT_ADDR_W'(OUT_DIM) + OUT_ADDR_W'(bx_q);

    assign last_in_window = (kx_q == K_W'(POOL - 1)) && (ky_q == K_W'(POOL - 1));
    assign last_cell      = (bx_q == C_W'(OUT_DIM - 1)) && (by_q == C_W'(OUT_DIM - 1));

endmodule

// File: rtl/average_pooling.sv
// Sums each POOLxPOOL block of the 1-bit frame buffer and writes the scaled,
// saturated grey level into the pooled-image RAM, one cell at a time.
module average_pooling #(
    parameter int IN_DIM     = pooling_pkg::IN_DIM,
    parameter int POOL       = pooling_pkg::POOL,
    parameter int OUT_BITS   = pooling_pkg::OUT_BITS,
    parameter int FB_ADDR_W  = pooling_pkg::FB_ADDR_W,
    parameter int OUT_ADDR_W = pooling_pkg::OUT_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    output logic                  done,
    output logic                  busy,
    output logic                  fb_rd_en,
    output logic [FB_ADDR_W-1:0]  fb_rd_addr,
    input  logic                  fb_rd_data,
    output logic                  pool_wr_en,
    output logic [OUT_ADDR_W-1:0] pool_wr_addr,
    output logic [OUT_BITS-1:0]   pool_wr_data
);

    import pooling_pkg::*;

    localparam int WIN_LOG2 = $clog2(POOL * POOL);
    localparam int ACC_W    = WIN_LOG2 + 1;
    localparam int SHIFT    = OUT_BITS - WIN_LOG2;
    localparam int SUM_W    = ACC_W + SHIFT;

    logic [2:0]       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rd_valid_q, rd_valid_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] scaled_wide;
    logic             start_ok;
    logic             step_cell;
    logic             last_in_window;
    logic             last_cell;

    assign start_ok   = start && enable && (state_q == ST_IDLE || state_q == ST_DONE);
    assign fb_rd_en   = enable && (state_q == ST_READ);
    assign pool_wr_en = enable && (state_q == ST_WRITE);
    assign step_cell  = pool_wr_en && !last_cell;

    // The read-valid flag follows every issued read regardless of enable,
    // so a datum in flight when enable drops is still counted.
    assign rd_valid_d = fb_rd_en;

    pool_addr_gen #(
        .IN_DIM     (IN_DIM),
        .POOL       (POOL),
        .FB_ADDR_W  (FB_ADDR_W),
        .OUT_ADDR_W (OUT_ADDR_W)
    ) u_addr_gen (
        .clk            (clk),
        .reset          (reset),
        .clear          (start_ok),
        .step_k         (fb_rd_en),
        .step_cell      (step_cell),
        .fb_addr        (fb_rd_addr),
        .cell_idx       (pool_wr_addr),
        .last_in_window (last_in_window),
        .last_cell      (last_cell)
    );

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = done_q;
        acc_d   = acc_q;
        if (rd_valid_q) begin
            acc_d = acc_q + ACC_W'(fb_rd_data);
        end
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d = ST_READ;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    acc_d   = '0;
                end
            end
            ST_READ: begin
                if (enable && last_in_window) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (enable) begin
                    acc_d = '0;
                    if (last_cell) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                acc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            acc_q      <= acc_d;
        end
    end

    // A completely filled window overflows OUT_BITS by one and clamps to all ones.
    assign scaled_wide  = SUM_W'(acc_q) << SHIFT;
    assign pool_wr_data = (scaled_wide > SUM_W'((1 << OUT_BITS) - 1)) ? '1
                                                                      : scaled_wide[OUT_BITS-1:0];
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_average_pooling.sv
// Bench for average_pooling on a reduced 64x64 frame (8x8 pooled image)
// against a block-sum reference model of the frame buffer.
module tb_average_pooling;

    localparam int IN_DIM      = 64;
    localparam int POOL        = 8;
    localparam int OUT_BITS    = 8;
    localparam int FB_ADDR_W   = 16;
    localparam int OUT_ADDR_W  = 10;
    localparam int OUT_DIM     = IN_DIM / POOL;
    localparam int CELLS       = OUT_DIM * OUT_DIM;
    localparam int CELL_CYCLES = POOL * POOL + 2;
    localparam int PASS_EDGES  = CELLS * CELL_CYCLES;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enable;
    logic                  start;
    logic                  done;
    logic                  busy;
    logic                  fb_rd_en;
    logic [FB_ADDR_W-1:0]  fb_rd_addr;
    logic                  fb_rd_data = 1'b0;
    logic                  pool_wr_en;
    logic [OUT_ADDR_W-1:0] pool_wr_addr;
    logic [OUT_BITS-1:0]   pool_wr_data;

    bit fb_mem [0:(1 << FB_ADDR_W) - 1];
    int wr_addr_q[$];
    int wr_data_q[$];
    int rd_idx = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    average_pooling #(
        .IN_DIM     (IN_DIM),
        .POOL       (POOL),
        .OUT_BITS   (OUT_BITS),
        .FB_ADDR_W  (FB_ADDR_W),
        .OUT_ADDR_W (OUT_ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .start        (start),
        .done         (done),
        .busy         (busy),
        .fb_rd_en     (fb_rd_en),
        .fb_rd_addr   (fb_rd_addr),
        .fb_rd_data   (fb_rd_data),
        .pool_wr_en   (pool_wr_en),
        .pool_wr_addr (pool_wr_addr),
        .pool_wr_data (pool_wr_data)
    );

    // One-cycle-latency frame buffer; junk on cycles without a read.
    always @(posedge clk) begin
        if (fb_rd_en) fb_rd_data <= fb_mem[fb_rd_addr];
        else          fb_rd_data <= 1'($urandom_range(0, 1));
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int exp_addr(input int n);
        int c = n / (POOL * POOL);
        int k = n % (POOL * POOL);
        return ((c / OUT_DIM) * POOL + k / POOL) * IN_DIM + (c % OUT_DIM) * POOL + k % POOL;
    endfunction

    function automatic int ref_cell(input int c);
        int s = 0;
        for (int y = 0; y < POOL; y++)
            for (int x = 0; x < POOL; x++)
                s += int'(fb_mem[((c / OUT_DIM) * POOL + y) * IN_DIM + (c % OUT_DIM) * POOL + x]);
        s = s * (1 << OUT_BITS) / (POOL * POOL);
        return (s > (1 << OUT_BITS) - 1) ? (1 << OUT_BITS) - 1 : s;
    endfunction

    always @(negedge clk) begin
        if (pool_wr_en) begin
            wr_addr_q.push_back(int'(pool_wr_addr));
            wr_data_q.push_back(int'(pool_wr_data));
        end
        if (fb_rd_en) begin
            checkOutput("rd_addr", int'(fb_rd_addr), exp_addr(rd_idx));
            rd_idx++;
        end
    end

    task automatic load_frame(input int mode);
        for (int i = 0; i < IN_DIM * IN_DIM; i++)
            fb_mem[i] = (mode == 1) ? 1'b1 : (mode == 4) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (mode == 2) begin
            fb_mem[0] = 1'b1;
            fb_mem[IN_DIM * IN_DIM - 1] = 1'b1;
        end
        if (mode == 3)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < POOL; c++)
                    fb_mem[r * IN_DIM + c] = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_rd_en"}, int'(fb_rd_en), 0);
        checkOutput({tag, "_wr_en"}, int'(pool_wr_en), 0);
        checkOutput({tag, "_rd_addr"}, int'(fb_rd_addr), 0);
        checkOutput({tag, "_wr_addr"}, int'(pool_wr_addr), 0);
        checkOutput({tag, "_wr_data"}, int'(pool_wr_data), 0);
    endtask

    // Runs one full pass from a start pulse and scores timing and every write.
    task automatic applyStimulus(input bit rand_en, input bit inject_start);
        int n = 0;
        int en_edges = 0;
        bit seen = 1'b0;
        int prev_busy;
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_idx = 0;
        start  = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", int'(busy), 1);
        checkOutput("done_after_start", int'(done), 0);
        prev_busy = int'(busy);
        while (!seen && n < 4 * PASS_EDGES) begin
            enable = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            start  = inject_start && (n == 300);
            @(posedge clk);
            if (enable) en_edges++;
            @(negedge clk);
            start = 1'b0;
            n++;
            if (done) begin
                seen = 1'b1;
                checkOutput("done_enabled_edges", en_edges, PASS_EDGES);
                checkOutput("busy_falls_with_done", int'(busy), 0);
                checkOutput("busy_before_done", prev_busy, 1);
            end
            prev_busy = int'(busy);
        end
        enable = 1'b1;
        checkOutput("done_seen", int'(seen), 1);
        repeat (3) @(negedge clk);
        checkOutput("done_held", int'(done), 1);
        checkOutput("wr_count", wr_addr_q.size(), CELLS);
        for (int c = 0; c < CELLS && c < wr_addr_q.size(); c++) begin
            checkOutput("wr_addr", wr_addr_q[c], c);
            checkOutput("wr_data", wr_data_q[c], ref_cell(c));
        end
    endtask

    initial begin
        int waited;
        reset  = 1'b1;
        enable = 1'b0;
        start  = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        start  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        enable = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("start_no_enable_busy", int'(busy), 0);
        checkOutput("start_no_enable_rd_en", int'(fb_rd_en), 0);

        $display("[TB] pass: all zeros");
        load_frame(0);
        applyStimulus(1'b0, 1'b0);

        $display("[TB] pass: all ones");
        load_frame(1);
        applyStimulus(1'b0, 1'b0);
        if (wr_data_q.size() == CELLS) checkOutput("ones_cell_sat", wr_data_q[CELLS / 2], 255);

        $display("[TB] pass: corner pixels");
        load_frame(2);
        applyStimulus(1'b0, 1'b0);
        if (wr_data_q.size() == CELLS) begin
            checkOutput("corner_cell_first", wr_data_q[0], 4);
            checkOutput("corner_cell_last", wr_data_q[CELLS - 1], 4);
            checkOutput("corner_cell_mid", wr_data_q[1], 0);
        end

        $display("[TB] pass: half block");
        load_frame(3);
        applyStimulus(1'b0, 1'b0);
        if (wr_data_q.size() == CELLS) begin
            checkOutput("half_block_cell0", wr_data_q[0], 128);
            checkOutput("half_block_cell1", wr_data_q[1], 0);
        end

        $display("[TB] pass: random frame, random enable");
        load_frame(4);
        applyStimulus(1'b1, 1'b0);

        $display("[TB] pass: reset mid-read");
        load_frame(4);
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_idx = 0;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (wr_addr_q.size() < 5 && waited < 4 * PASS_EDGES) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("abort_writes_reached", int'(wr_addr_q.size() >= 5), 1);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        check_idle_outputs("mid_reset_hold");
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
